// File: rtl/reg_file_wb.sv
// Writeback stage plus 32-entry register file: selects and extends the result,
// writes it back, and serves two decode-stage reads with write-first bypass.
module reg_file_wb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FUNCT3_WIDTH  = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcW,
    input  logic [DATA_WIDTH-1:0]    ALUResultW,
    input  logic [DATA_WIDTH-1:0]    ReadDataW,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic [DATA_WIDTH-1:0]    PCPlus4W,
    input  logic [FUNCT3_WIDTH-1:0]  funct3W,
    input  logic [ADDRESS_WIDTH-1:0] A1,
    input  logic [ADDRESS_WIDTH-1:0] A2,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic [DATA_WIDTH-1:0]    ResultW,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic [31:0]              WriteCount
);

    localparam int NREGS = 1 << ADDRESS_WIDTH;
    localparam logic [FUNCT3_WIDTH-1:0] F3_LB  = FUNCT3_WIDTH'(0);
    localparam logic [FUNCT3_WIDTH-1:0] F3_LH  = FUNCT3_WIDTH'(1);
    localparam logic [FUNCT3_WIDTH-1:0] F3_LBU = FUNCT3_WIDTH'(4);
    localparam logic [FUNCT3_WIDTH-1:0] F3_LHU = FUNCT3_WIDTH'(5);

    logic [DATA_WIDTH-1:0] r_regs [NREGS];
    logic [31:0]           r_write_count;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_wr_en;

    // Lane select and extension of the aligned memory word; halfwords ignore addr[0].
    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0]   word,
        input logic [1:0]              addr,
        input logic [FUNCT3_WIDTH-1:0] f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (addr)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   load_extract = {{(DATA_WIDTH-8){b[7]}}, b};
            F3_LH:   load_extract = {{(DATA_WIDTH-16){h[15]}}, h};
            F3_LBU:  load_extract = {{(DATA_WIDTH-8){1'b0}}, b};
            F3_LHU:  load_extract = {{(DATA_WIDTH-16){1'b0}}, h};
            default: load_extract = word;
        endcase
    endfunction

    always_comb begin
        w_load_data = load_extract(ReadDataW, ALUResultW[1:0], funct3W);
        w_result    = ALUResultW;
        case (ResultSrcW)
            2'b01:   w_result = w_load_data;
            2'b10:   w_result = PCPlus4W;
            default: w_result = ALUResultW;
        endcase
    end

    // Reset suppresses both the write and the bypass in the same cycle.
    assign w_wr_en = RegWriteW && (RdW != '0) && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_write_count <= '0;
        end else if (w_wr_en) begin
            r_regs[RdW]   <= w_result;
            r_write_count <= r_write_count + 32'd1;
        end
    end

    always_comb begin
        RD1 = r_regs[A1];
        RD2 = r_regs[A2];
        if (A1 == '0) begin
            RD1 = '0;
        end else if (w_wr_en && (A1 == RdW)) begin
            RD1 = w_result;
        end
        if (A2 == '0) begin
            RD2 = '0;
        end else if (w_wr_en && (A2 == RdW)) begin
            RD2 = w_result;
        end
    end

    assign ResultW    = w_result;
    assign a0         = r_regs[10];
    assign WriteCount = r_write_count;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus randomized traffic
// compared against an array-based architectural model.
module tb_reg_file_wb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;
    logic [2:0]  funct3W;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] a0;
    logic [31:0] WriteCount;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    reg_file_wb #(
        .ADDRESS_WIDTH(5),
        .DATA_WIDTH   (32),
        .FUNCT3_WIDTH (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RegWriteW (RegWriteW),
        .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW),
        .ReadDataW (ReadDataW),
        .RdW       (RdW),
        .PCPlus4W  (PCPlus4W),
        .funct3W   (funct3W),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .ResultW   (ResultW),
        .a0        (a0),
        .WriteCount(WriteCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Architectural result computed from shifts and masks on the memory word.
    function automatic logic [31:0] model_result();
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] ld;
        b = (ReadDataW >> (8 * ALUResultW[1:0])) & 32'hFF;
        h = (ReadDataW >> (16 * ALUResultW[1])) & 32'hFFFF;
        case (funct3W)
            3'd0:    ld = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    ld = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4:    ld = b;
            3'd5:    ld = h;
            default: ld = ReadDataW;
        endcase
        if (ResultSrcW == 2'd1) return ld;
        if (ResultSrcW == 2'd2) return PCPlus4W;
        return ALUResultW;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!RST && RegWriteW && RdW != 5'd0 && a == RdW) return model_result();
        return m_regs[a];
    endfunction

    // Compare every combinational output, take one edge, then advance the model.
    task automatic cycle();
        #1;
        check("result", ResultW, model_result());
        check("rd1", RD1, model_read(A1));
        check("rd2", RD2, model_read(A2));
        check("a0", a0, m_regs[10]);
        check("wcount", WriteCount, m_count);
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_count = 32'd0;
        end else if (RegWriteW && RdW != 5'd0) begin
            m_regs[RdW] = model_result();
            m_count     = m_count + 32'd1;
        end
        #1;
    endtask

    task automatic idle();
        RST = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'd0; ALUResultW = 32'd0;
        ReadDataW = 32'd0; RdW = 5'd0; PCPlus4W = 32'd0; funct3W = 3'd0;
        A1 = 5'd0; A2 = 5'd0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hDEAD_BEEF;
        m_count = 32'hDEAD_BEEF;
        idle();
        RST = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd3; ALUResultW = 32'h55;
        @(posedge CLK);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count = 32'd0;
        #1;
        idle();
        A1 = 5'd3; A2 = 5'd10;
        #1;
        check("reset_rd1", RD1, 32'd0);
        check("reset_rd2", RD2, 32'd0);
        check("reset_a0", a0, 32'd0);
        check("reset_count", WriteCount, 32'd0);

        // Write x5 with bypass, then read back from storage.
        RegWriteW = 1'b1; RdW = 5'd5; ResultSrcW = 2'd0; ALUResultW = 32'h1234_5678;
        A1 = 5'd5; A2 = 5'd5;
        #1;
        check("bypass_rd1", RD1, 32'h1234_5678);
        check("bypass_rd2", RD2, 32'h1234_5678);
        cycle();
        idle(); A1 = 5'd5;
        #1;
        check("stored_rd1", RD1, 32'h1234_5678);
        check("count_one", WriteCount, 32'd1);

        // Load byte and halfword extraction.
        ResultSrcW = 2'd1; ReadDataW = 32'h80FF_7F01; funct3W = 3'd0; ALUResultW = 32'd3;
        #1; check("lb_lane3", ResultW, 32'hFFFF_FF80);
        funct3W = 3'd4;
        #1; check("lbu_lane3", ResultW, 32'h0000_0080);
        funct3W = 3'd0; ALUResultW = 32'd2;
        #1; check("lb_lane2", ResultW, 32'hFFFF_FFFF);
        funct3W = 3'd1; ALUResultW = 32'd2;
        #1; check("lh_hi", ResultW, 32'hFFFF_80FF);
        funct3W = 3'd5; ALUResultW = 32'd0;
        #1; check("lhu_lo", ResultW, 32'h0000_7F01);
        ALUResultW = 32'd1;
        #1; check("lhu_bit0_ignored", ResultW, 32'h0000_7F01);
        funct3W = 3'd2;
        #1; check("lw", ResultW, 32'h80FF_7F01);
        funct3W = 3'd7;
        #1; check("l_other", ResultW, 32'h80FF_7F01);
        cycle();

        // Write to x0 via the link value is discarded.
        idle();
        RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'd2; PCPlus4W = 32'h44; A1 = 5'd0;
        #1; check("x0_rd1_bypass", RD1, 32'd0);
        check("link_result", ResultW, 32'h44);
        cycle();
        idle();
        #1; check("x0_rd1_after", RD1, 32'd0);
        check("x0_count", WriteCount, 32'd1);

        // a0 updates only after the edge.
        RegWriteW = 1'b1; RdW = 5'd10; ALUResultW = 32'h2A; A1 = 5'd10;
        #1; check("a0_before", a0, 32'd0);
        check("a0_bypass_rd1", RD1, 32'h2A);
        cycle();
        idle();
        #1; check("a0_after", a0, 32'h2A);

        // Reset with a pending write discards it and clears everything.
        RegWriteW = 1'b1; RdW = 5'd10; ALUResultW = 32'd7;
        cycle();
        idle();
        #1; check("x10_seven", a0, 32'd7);
        check("count_three", WriteCount, 32'd3);
        RST = 1'b1; RegWriteW = 1'b1; RdW = 5'd10; ALUResultW = 32'd99; A1 = 5'd10; A2 = 5'd5;
        #1; check("rst_no_bypass", RD1, 32'd7);
        check("rst_stored_rd2", RD2, 32'h1234_5678);
        cycle();
        idle(); A1 = 5'd10; A2 = 5'd5;
        #1; check("rst_x10", RD1, 32'd0);
        check("rst_x5", RD2, 32'd0);
        check("rst_a0", a0, 32'd0);
        check("rst_count", WriteCount, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            RST        = ($urandom_range(0, 40) == 0);
            RegWriteW  = ($urandom_range(0, 3) != 0);
            ResultSrcW = 2'($urandom_range(0, 3));
            ALUResultW = $urandom;
            ReadDataW  = $urandom;
            RdW        = 5'($urandom_range(0, 31));
            PCPlus4W   = $urandom;
            funct3W    = 3'($urandom_range(0, 7));
            A1         = ($urandom_range(0, 2) == 0) ? RdW : 5'($urandom_range(0, 31));
            A2         = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom_range(0, 31));
            cycle();
        end

        idle();
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            #1;
            check("final_rd1", RD1, m_regs[i]);
            check("final_rd2", RD2, m_regs[31 - i]);
        end
        check("final_count", WriteCount, m_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
